// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-address controller for the five-stage MIPS pipeline.
// Owns the F-stage PC, resolves D-stage branches/jumps with full compare
// logic, handles CP0 exception entry and eret return, flags illegal fetch
// addresses and keeps a return-address stack that reports mispredicted jr.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_stall         hazard-unit freeze of F/D
//   i_branch[3:0]   D-stage control code (0 none .. 10 jalr, 11-15 none)
//   i_rs_D, i_rt_D  forwarded D-stage operands
//   i_imm26         instr_index; [15:0] is the branch offset
//   i_PC4_D         PC+4 of the D-stage instruction
//   i_exc, i_eret   CP0 exception entry / eret return
//   i_epc           CP0 EPC
//   o_PC            registered fetch address
//   o_nextPC        PC for the next edge (combinational, ignores stall)
//   o_taken         D-stage control transfer taken
//   o_adel          fetch address misaligned or out of range
//   o_ras_miss      one-cycle pulse after a mispredicted jr
module pc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_PC    = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO   = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI   = 32'h0000_6FFC,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stall,
  input  logic [3:0]  i_branch,
  input  logic [31:0] i_rs_D,
  input  logic [31:0] i_rt_D,
  input  logic [25:0] i_imm26,
  input  logic [31:0] i_PC4_D,
  input  logic        i_exc,
  input  logic        i_eret,
  input  logic [31:0] i_epc,
  output logic [31:0] o_PC,
  output logic [31:0] o_nextPC,
  output logic        o_taken,
  output logic        o_adel,
  output logic        o_ras_miss
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLEZ = 4'd3,
    BR_BGTZ = 4'd4,
    BR_BLTZ = 4'd5,
    BR_BGEZ = 4'd6,
    BR_J    = 4'd7,
    BR_JAL  = 4'd8,
    BR_JR   = 4'd9,
    BR_JALR = 4'd10
  } br_e;

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] tgt;
  logic        taken;
  logic        is_push;
  logic        is_pop;
  logic        accept;
  logic        pc_load;

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_ptr;
  logic [CW-1:0] ras_cnt;
  logic [PW-1:0] top_idx;
  logic          ras_hit;

  assign br_tgt = i_PC4_D + {{14{i_imm26[15]}}, i_imm26[15:0], 2'b00};
  assign j_tgt  = {i_PC4_D[31:28], i_imm26, 2'b00};

  always_comb begin
    taken   = 1'b0;
    tgt     = br_tgt;
    is_push = 1'b0;
    is_pop  = 1'b0;
    case (i_branch)
      BR_BEQ:  taken = (i_rs_D == i_rt_D);
      BR_BNE:  taken = (i_rs_D != i_rt_D);
      BR_BLEZ: taken = ($signed(i_rs_D) <= 32'sd0);
      BR_BGTZ: taken = ($signed(i_rs_D) >  32'sd0);
      BR_BLTZ: taken = ($signed(i_rs_D) <  32'sd0);
      BR_BGEZ: taken = ($signed(i_rs_D) >= 32'sd0);
      BR_J: begin
        taken = 1'b1;
        tgt   = j_tgt;
      end
      BR_JAL: begin
        taken   = 1'b1;
        tgt     = j_tgt;
        is_push = 1'b1;
      end
      BR_JR: begin
        taken  = 1'b1;
        tgt    = i_rs_D;
        is_pop = 1'b1;
      end
      BR_JALR: begin
        taken   = 1'b1;
        tgt     = i_rs_D;
        is_push = 1'b1;
      end
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    o_nextPC = o_PC + 32'd4;
    if (i_exc)       o_nextPC = EXC_PC;
    else if (i_eret) o_nextPC = i_epc;
    else if (taken)  o_nextPC = tgt;
  end

  assign o_taken = taken;
  assign o_adel  = (o_PC[1:0] != 2'b00) | (o_PC < IMEM_LO) | (o_PC > IMEM_HI);

  // Exception/eret override the hazard freeze; the RAS only moves when the
  // D instruction actually retires its transfer (unstalled, no redirect).
  assign pc_load = !i_stall | i_exc | i_eret;
  assign accept  = !i_stall & !i_exc & !i_eret;

  // ras_ptr is the next free slot; the top entry sits one below it.
  assign top_idx = ras_ptr - PW'(1);
  assign ras_hit = (ras_cnt != '0) && (ras_mem[top_idx] == i_rs_D);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_PC       <= RESET_PC;
      ras_ptr    <= '0;
      ras_cnt    <= '0;
      o_ras_miss <= 1'b0;
    end else begin
      if (pc_load) o_PC <= o_nextPC;
      o_ras_miss <= accept & is_pop & !ras_hit;
      if (accept && is_push) begin
        ras_ptr <= ras_ptr + PW'(1);
        if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + CW'(1);
      end else if (accept && is_pop && ras_cnt != '0) begin
        ras_ptr <= top_idx;
        ras_cnt <= ras_cnt - CW'(1);
      end
    end
  end

  // Entries carry no reset value; count/pointer gate their validity.
  always_ff @(posedge clk) begin
    if (!reset && accept && is_push) ras_mem[ras_ptr] <= i_PC4_D + 32'd4;
  end

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

  logic        clk;
  logic        reset;
  logic        i_stall;
  logic [3:0]  i_branch;
  logic [31:0] i_rs_D;
  logic [31:0] i_rt_D;
  logic [25:0] i_imm26;
  logic [31:0] i_PC4_D;
  logic        i_exc;
  logic        i_eret;
  logic [31:0] i_epc;
  logic [31:0] o_PC;
  logic [31:0] o_nextPC;
  logic        o_taken;
  logic        o_adel;
  logic        o_ras_miss;

  pc_ctrl #(
    .RESET_PC (32'h0000_3000),
    .EXC_PC   (32'h0000_4180),
    .IMEM_LO  (32'h0000_3000),
    .IMEM_HI  (32'h0000_6FFC),
    .RAS_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_stall   (i_stall),
    .i_branch  (i_branch),
    .i_rs_D    (i_rs_D),
    .i_rt_D    (i_rt_D),
    .i_imm26   (i_imm26),
    .i_PC4_D   (i_PC4_D),
    .i_exc     (i_exc),
    .i_eret    (i_eret),
    .i_epc     (i_epc),
    .o_PC      (o_PC),
    .o_nextPC  (o_nextPC),
    .o_taken   (o_taken),
    .o_adel    (o_adel),
    .o_ras_miss(o_ras_miss)
  );

  localparam int unsigned SEL_PC    = 0;
  localparam int unsigned SEL_NEXT  = 1;
  localparam int unsigned SEL_TAKEN = 2;
  localparam int unsigned SEL_ADEL  = 3;
  localparam int unsigned SEL_MISS  = 4;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int unsigned sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] dut_out(input int unsigned sel);
    case (sel)
      SEL_PC:    return o_PC;
      SEL_NEXT:  return o_nextPC;
      SEL_TAKEN: return {31'd0, o_taken};
      SEL_ADEL:  return {31'd0, o_adel};
      default:   return {31'd0, o_ras_miss};
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, dut_out(e.sel), e.val);
    end
  endtask

  // Registered outputs: expectations queued before the edge, compared after it.
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  // Combinational outputs: compared at the next falling edge.
  task automatic settle();
    @(negedge clk);
    drain();
  endtask

  initial begin
    reset = 1'b1; i_stall = 1'b0; i_branch = 4'd0; i_rs_D = '0; i_rt_D = '0;
    i_imm26 = '0; i_PC4_D = '0; i_exc = 1'b0; i_eret = 1'b0; i_epc = '0;
    tick();
    tick();
    reset = 1'b0;
    expect_val("reset_pc", SEL_PC, 32'h3000);
    expect_val("reset_adel", SEL_ADEL, 32'd0);
    expect_val("reset_miss", SEL_MISS, 32'd0);
    settle();
    for (int i = 1; i <= 3; i++) begin
      expect_val("seq_pc", SEL_PC, 32'h3000 + 32'(i) * 32'd4);
      expect_val("seq_adel", SEL_ADEL, 32'd0);
      tick();
    end

    // Combinational branch resolution, PC frozen at 0x300C.
    i_stall = 1'b1;
    i_branch = 4'd1; i_PC4_D = 32'h3008; i_rs_D = 32'd5; i_rt_D = 32'd5; i_imm26 = 26'h000FFFE;
    expect_val("beq_next", SEL_NEXT, 32'h3000);
    expect_val("beq_taken", SEL_TAKEN, 32'd1);
    settle();
    i_rt_D = 32'd6;
    expect_val("beq_nt_taken", SEL_TAKEN, 32'd0);
    expect_val("beq_nt_next", SEL_NEXT, 32'h3010);
    settle();
    i_branch = 4'd5; i_rs_D = 32'h8000_0000;
    expect_val("bltz_taken", SEL_TAKEN, 32'd1);
    expect_val("bltz_next", SEL_NEXT, 32'h3000);
    settle();
    i_rs_D = 32'd0;
    i_branch = 4'd3; expect_val("blez_zero", SEL_TAKEN, 32'd1); settle();
    i_branch = 4'd4; expect_val("bgtz_zero", SEL_TAKEN, 32'd0); settle();
    i_branch = 4'd6; expect_val("bgez_zero", SEL_TAKEN, 32'd1); settle();
    i_branch = 4'd5; expect_val("bltz_zero", SEL_TAKEN, 32'd0); settle();
    i_branch = 4'd12; expect_val("code12_taken", SEL_TAKEN, 32'd0); settle();
    i_branch = 4'd7; i_imm26 = 26'h0000C10;
    expect_val("j_next", SEL_NEXT, 32'h3040);
    expect_val("j_taken", SEL_TAKEN, 32'd1);
    settle();
    i_branch = 4'd0; i_stall = 1'b0;
    expect_val("post_comb_pc", SEL_PC, 32'h3010);
    tick();

    // Stalled bne, then exception breaking through a stall.
    i_stall = 1'b1; i_branch = 4'd2; i_rs_D = 32'd1; i_rt_D = 32'd2;
    i_PC4_D = 32'h3010; i_imm26 = 26'h0000004;
    expect_val("stall1_pc", SEL_PC, 32'h3010); tick();
    expect_val("stall2_pc", SEL_PC, 32'h3010); tick();
    i_stall = 1'b0;
    expect_val("bne_target_pc", SEL_PC, 32'h3020); tick();
    i_branch = 4'd0; i_stall = 1'b1; i_exc = 1'b1;
    expect_val("exc_stall_pc", SEL_PC, 32'h4180); tick();
    i_exc = 1'b0; i_stall = 1'b0;

    // RAS predict hit, miss and empty.
    i_branch = 4'd8; i_PC4_D = 32'h3010; i_imm26 = 26'h0000C00;
    expect_val("jal_pc", SEL_PC, 32'h3000);
    expect_val("jal_miss", SEL_MISS, 32'd0); tick();
    i_branch = 4'd9; i_rs_D = 32'h3014;
    expect_val("jr_hit_pc", SEL_PC, 32'h3014);
    expect_val("jr_hit_miss", SEL_MISS, 32'd0); tick();
    i_branch = 4'd0; expect_val("idle_miss", SEL_MISS, 32'd0); tick();
    i_branch = 4'd8; tick();
    i_branch = 4'd9; i_rs_D = 32'h3020;
    expect_val("jr_bad_miss", SEL_MISS, 32'd1); tick();
    i_branch = 4'd0; expect_val("jr_bad_pulse_end", SEL_MISS, 32'd0); tick();
    i_branch = 4'd9; i_rs_D = 32'h3000;
    expect_val("jr_empty_miss", SEL_MISS, 32'd1); tick();
    i_stall = 1'b1;
    expect_val("jr_stalled_miss", SEL_MISS, 32'd0); tick();
    i_stall = 1'b0; i_branch = 4'd0;
    expect_val("idle2_miss", SEL_MISS, 32'd0); tick();

    // Overflow: five pushes into a four-deep stack, then five pops.
    for (int i = 0; i < 5; i++) begin
      i_branch = 4'd8; i_PC4_D = 32'h3100 + 32'(i) * 32'h100;
      expect_val("push_miss", SEL_MISS, 32'd0);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      i_branch = 4'd9; i_rs_D = 32'h3504 - 32'(k) * 32'h100;
      expect_val("pop_pc", SEL_PC, 32'h3504 - 32'(k) * 32'h100);
      expect_val("pop_miss", SEL_MISS, (k == 4) ? 32'd1 : 32'd0);
      tick();
    end
    i_branch = 4'd0; expect_val("pop_done_miss", SEL_MISS, 32'd0); tick();

    // Reset mid-operation beats exc and clears the stack.
    i_branch = 4'd8; i_PC4_D = 32'h3010; tick();
    reset = 1'b1; i_branch = 4'd0; i_exc = 1'b1;
    expect_val("midreset_pc", SEL_PC, 32'h3000);
    expect_val("midreset_miss", SEL_MISS, 32'd0); tick();
    reset = 1'b0; i_exc = 1'b0;
    i_branch = 4'd9; i_rs_D = 32'h3014;
    expect_val("postreset_jr_pc", SEL_PC, 32'h3014);
    expect_val("postreset_jr_miss", SEL_MISS, 32'd1); tick();
    i_branch = 4'd0;

    // eret through a stall, address-error boundaries, exc over eret.
    i_stall = 1'b1; i_eret = 1'b1; i_epc = 32'h3002;
    expect_val("eret_pc", SEL_PC, 32'h3002);
    expect_val("eret_misalign_adel", SEL_ADEL, 32'd1); tick();
    i_epc = 32'h7000;
    expect_val("eret_hi_adel", SEL_ADEL, 32'd1); tick();
    i_epc = 32'h6FFC;
    expect_val("eret_top_adel", SEL_ADEL, 32'd0); tick();
    i_epc = 32'h2FFC;
    expect_val("eret_lo_adel", SEL_ADEL, 32'd1); tick();
    i_exc = 1'b1;
    expect_val("exc_over_eret_pc", SEL_PC, 32'h4180); tick();
    i_exc = 1'b0; i_eret = 1'b0;
    expect_val("held_pc", SEL_PC, 32'h4180); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch-address controller for the five-stage MIPS pipeline. It owns the F-stage PC register and resolves D-stage branches and jumps with full comparison logic, which replaces the external zero flag. It also handles CP0 exception entry and `eret` return, flags misaligned or out-of-range fetch addresses, and keeps a parametrised return-address stack (RAS) that reports mispredicted `jr` returns to the performance/debug logic. It sits between the hazard unit, the D-stage forwarding muxes, CP0 and the instruction memory.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- EXC_PC, 32'h0000_4180, exception/interrupt handler entry
- IMEM_LO, 32'h0000_3000, lowest legal fetch address
- IMEM_HI, 32'h0000_6FFC, highest legal fetch address
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- i_stall  in  1  hazard-unit freeze of F/D
- i_branch  in  4  D-stage control code: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 j, 8 jal, 9 jr, 10 jalr; 11–15 behave as none
- i_rs_D  in  32  forwarded rs value (compare operand / jr target)
- i_rt_D  in  32  forwarded rt value
- i_imm26  in  26  instr_index; bits [15:0] are the branch offset
- i_PC4_D  in  32  PC+4 of the D-stage instruction
- i_exc  in  1  CP0 requests exception/interrupt entry
- i_eret  in  1  `eret` in the commit stage
- i_epc  in  32  CP0 EPC
- o_PC  out  32  current fetch address (registered)
- o_nextPC  out  32  PC value for the next edge (combinational)
- o_taken  out  1  D-stage control transfer taken (combinational)
- o_adel  out  1  fetch address misaligned or outside [IMEM_LO, IMEM_HI]
- o_ras_miss  out  1  registered one-cycle pulse: last `jr` mispredicted by the RAS

## Operation
- Branch conditions use signed 32-bit compares:
  - beq: rs==rt
  - bne: rs!=rt
  - blez: rs≤0
  - bgtz: rs>0
  - bltz: rs<0
  - bgez: rs≥0
- Branch target = i_PC4_D + {{14{imm[15]}}, imm[15:0], 2'b00}, modulo 2^32.
- j/jal target = {i_PC4_D[31:28], i_imm26, 2'b00}. jr/jalr target = i_rs_D.
- o_taken = 1 for a true branch condition and for codes 7–10.
- o_nextPC priority, highest first:
  - i_exc → EXC_PC
  - i_eret → i_epc
  - o_taken → target
  - otherwise o_PC+4
- The stall is applied at the register, not in o_nextPC.
- PC register: loads o_nextPC when (!i_stall | i_exc | i_eret). Exception and eret override a stall.
- o_adel = (o_PC[1:0]!=0) | (o_PC<IMEM_LO) | (o_PC>IMEM_HI), unsigned, combinational.
- RAS updates only on an accepted cycle: !i_stall & !i_exc & !i_eret & !reset.
- Push (jal, jalr): write i_PC4_D+4 (return past the delay slot) at the top pointer.
  - The pointer increments modulo RAS_DEPTH.
  - count saturates at RAS_DEPTH, so the oldest entry is overwritten when full.
- Pop (jr):
  - count==0: o_ras_miss=1 next cycle, pointer unchanged.
  - Otherwise compare the top entry with i_rs_D: mismatch gives o_ras_miss=1 next cycle, match gives 0.
  - The pointer decrements and count decrements.
- jalr pushes only and never pops. i_exc and i_eret leave the RAS untouched.
- o_ras_miss is 0 in every cycle not directly following an accepted jr.

## Timing
- Reset values:
  - o_PC=RESET_PC
  - RAS count=0, pointer=0, entries don't-care
  - o_ras_miss=0
- After reset: o_adel reflects RESET_PC (0 with defaults), o_taken and o_nextPC follow the inputs.
- Reset asserted mid-operation wins over exc/eret/stall on that edge.
- Redirect latency: a D-stage transfer is visible on o_PC one edge later; the F instruction at that edge is the delay slot.
- Under a stall with no exc/eret, o_PC and the RAS hold for every stalled cycle. The D instruction is re-evaluated each cycle and acts once, on the first unstalled edge.
- Simultaneous i_exc and i_eret → exception wins.

## Test plan
- Reset, then 3 unstalled cycles, i_branch=0 → o_PC sequence 0x3000, 0x3004, 0x3008, 0x300C; o_adel=0.
- i_PC4_D=0x3008, beq, rs=rt=5, imm=0xFFFE → o_nextPC=0x3000, o_taken=1. Same with rt=6 → o_taken=0, o_nextPC=o_PC+4. bltz rs=0x80000000 → taken.
- bne taken with i_stall=1 for 2 cycles → o_PC held both cycles, loads the target on the first unstalled edge. Raise i_exc during the stall → o_PC=0x4180 on the next edge.
- jal at i_PC4_D=0x3010, later jr rs=0x3014 → o_ras_miss stays 0. jr rs=0x3020 → o_ras_miss=1 for exactly one cycle. jr on an empty RAS → o_ras_miss=1.
- Five jal pushes (RAS_DEPTH=4, returns A–E) then four jr with matching E, D, C, B → no miss. Fifth jr → miss (empty).
- i_eret with i_epc=0x3002 → o_PC=0x3002, o_adel=1. i_epc=0x7000 → o_adel=1.
